// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared control encodings for the RV32I multicycle controller: state codes,
// opcodes and the datapath mux/ALU select codes used by decoder and ALU decoder.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECR    = 4'd7,
        ST_EXECI    = 4'd8,
        ST_ALUWB    = 4'd9,
        ST_BEQ      = 4'd10,
        ST_JAL      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Wait counter for memory handshakes; flags when the allowed wait is used up.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [TW-1:0] count;

    // Clear has priority so a new access always starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == TW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control unit.
//   state    | meaning
//   RESET    | post-reset idle, all controls low
//   FETCH    | read instruction at PC, PC <= PC+4 on completion
//   DECODE   | branch target into ALUOut, dispatch on opcode
//   MEMADR   | rs1 + imm into ALUOut
//   MEMREAD  | load data read at ALUOut
//   MEMWB    | load data to rd
//   MEMWRITE | store at ALUOut
//   EXECR    | R-type ALU operation
//   EXECI    | I-type ALU operation
//   ALUWB    | ALUOut to rd
//   BEQ      | compare rs1/rs2, take branch on zero
//   JAL      | jump to target, PC+4 into ALUOut
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err
);

    state_t state;
    state_t next_state;
    logic   mem_state;
    logic   timeout;
    logic   timed_out;
    logic   pc_update;
    logic   branch;

    assign mem_state = (state == ST_FETCH) || (state == ST_MEMREAD) || (state == ST_MEMWRITE);
    assign timed_out = mem_state && timeout && !mem_ready;

    // Counter restarts whenever an access completes, aborts or is not in progress.
    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TW            (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!mem_state || mem_ready || timed_out),
        .en     (mem_state && !mem_ready),
        .timeout(timeout)
    );

    // Next-state selection; a timeout in any memory state abandons to FETCH.
    always_comb begin
        next_state = state;
        case (state)
            ST_RESET:    next_state = ST_FETCH;
            ST_FETCH:    if (mem_ready) next_state = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = ST_MEMADR;
                    OP_RTYPE:     next_state = ST_EXECR;
                    OP_ITYPE:     next_state = ST_EXECI;
                    OP_BEQ:       next_state = ST_BEQ;
                    OP_JAL:       next_state = ST_JAL;
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_MEMADR:   next_state = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  if (mem_ready) next_state = ST_MEMWB;
            ST_MEMWB:    next_state = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) next_state = ST_FETCH;
            ST_EXECR:    next_state = ST_ALUWB;
            ST_EXECI:    next_state = ST_ALUWB;
            ST_ALUWB:    next_state = ST_FETCH;
            ST_BEQ:      next_state = ST_FETCH;
            ST_JAL:      next_state = ST_ALUWB;
            default:     next_state = ST_FETCH;
        endcase
        if (timed_out) next_state = ST_FETCH;
    end

    // State register; reset lands in RESET so every control is low at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Control decode from state; only FETCH/MEMWRITE/BEQ/DECODE look at inputs.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        bus_err    = timed_out;
        imm_src    = imm_src_of(op);
        case (state)
            ST_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: illegal_op = 1'b0;
                    default:                                         illegal_op = 1'b1;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_FUNCT;
            end
            ST_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            ST_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: begin
                bus_err = timed_out;
            end
        endcase
        pc_write = pc_update || (branch && zero);
    end

endmodule
